// File: rtl/bit_balance_encoder_if.sv
// rtl/bit_balance_encoder_if.sv - byte-in / encoded-byte-out handshake bundle for the balance encoder
`timescale 1ns/1ps
interface bit_balance_encoder_if #(
  parameter int DISP_W = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic [7:0]               in_data;
  logic [3:0]               in_cnt;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [7:0]               out_data;
  logic                     out_inv;
  logic                     out_last;
  logic signed [DISP_W-1:0] out_rd;
  logic                     err;

  // Upstream byte source plus downstream consumer, seen from outside the encoder
  modport master (
    output in_valid, in_data, in_cnt, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_inv, out_last, out_rd, err
  );

  // The encoder itself
  modport slave (
    input  in_valid, in_data, in_cnt, in_last, out_ready,
    output in_ready, out_valid, out_data, out_inv, out_last, out_rd, err
  );
endinterface

// File: rtl/bit_balance_encoder.sv
// rtl/bit_balance_encoder.sv - conditional byte inverter keeping running disparity bounded
`timescale 1ns/1ps
module bit_balance_encoder #(
  parameter int DISP_W = 5
) (
  input logic                   clk,
  input logic                   rst,
  bit_balance_encoder_if.slave  bus
);

  logic                     valid_q, valid_d;
  logic [7:0]               data_q, data_d;
  logic                     inv_q, inv_d;
  logic                     last_q, last_d;
  logic signed [DISP_W-1:0] rd_out_q, rd_out_d;
  logic signed [DISP_W-1:0] rd_q, rd_d;
  logic                     err_q, err_d;

  logic                     in_ready;
  logic                     accept;
  logic                     legal;
  logic signed [7:0]        bd8;
  logic signed [DISP_W-1:0] bd;
  logic signed [DISP_W-1:0] ad;
  logic signed [DISP_W-1:0] rd_next;
  logic                     rd_pos, rd_neg, bd_pos, bd_neg;
  logic                     inv;

  // The 1-deep output slot frees up when empty or when it is being drained this cycle
  assign in_ready = !valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // Byte disparity and invert decision; an illegal count never inverts and never moves RD
  always_comb begin
    legal   = (bus.in_cnt <= 4'd8);
    bd8     = $signed({3'b000, bus.in_cnt, 1'b0}) - 8'sd8;
    bd      = DISP_W'(bd8);
    rd_neg  = rd_q[DISP_W-1];
    rd_pos  = !rd_q[DISP_W-1] && (rd_q != '0);
    bd_neg  = bd[DISP_W-1];
    bd_pos  = !bd[DISP_W-1] && (bd != '0);
    inv     = legal && ((rd_pos && bd_pos) || (rd_neg && bd_neg));
    ad      = inv ? -bd : bd;
    rd_next = legal ? (rd_q + ad) : rd_q;
  end

  // Next-state for the output slot, running disparity and sticky error
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    inv_d    = inv_q;
    last_d   = last_q;
    rd_out_d = rd_out_q;
    rd_d     = rd_q;
    err_d    = err_q;
    if (accept) begin
      valid_d  = 1'b1;
      data_d   = inv ? ~bus.in_data : bus.in_data;
      inv_d    = inv;
      last_d   = bus.in_last;
      rd_out_d = (!legal && bus.in_last) ? '0 : rd_next;
      rd_d     = bus.in_last ? '0 : rd_next;
      err_d    = err_q || !legal;
    end else if (bus.out_ready) begin
      valid_d  = 1'b0;
    end
  end

  // State registers; reset drops any held output and rebalances RD
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
      inv_q    <= 1'b0;
      last_q   <= 1'b0;
      rd_out_q <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      inv_q    <= inv_d;
      last_q   <= last_d;
      rd_out_q <= rd_out_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_inv   = inv_q;
  assign bus.out_last  = last_q;
  assign bus.out_rd    = rd_out_q;
  assign bus.err       = err_q;

endmodule
